// File: rtl/gyro_bias_cal.sv
`default_nettype none
// ============================================================================
// Module : gyro_bias_cal
// Averages 2^CAL_LOG2 samples per axis into a bias estimate, then streams
// bias-corrected, saturated and deadbanded gyro rates.
// Rev    : 1.0  initial release
// ============================================================================

module gyro_bias_cal #(
  parameter int CAL_LOG2 = 8,
  parameter int DEADBAND = 16
) (
  input  logic               clk_100mhz,
  input  logic               rst_in,
  input  logic signed [15:0] gx_in,
  input  logic signed [15:0] gy_in,
  input  logic signed [15:0] gz_in,
  input  logic               valid_in,
  input  logic               recal_in,
  output logic signed [15:0] gx_out,
  output logic signed [15:0] gy_out,
  output logic signed [15:0] gz_out,
  output logic               valid_out,
  output logic               cal_done_out,
  output logic signed [15:0] bias_x_out,
  output logic signed [15:0] bias_y_out,
  output logic signed [15:0] bias_z_out
);

  localparam int                  c_ACC_W    = 16 + CAL_LOG2;
  localparam logic [CAL_LOG2-1:0] c_LAST_CNT = {CAL_LOG2{1'b1}};
  localparam logic [CAL_LOG2-1:0] c_CNT_ONE  = CAL_LOG2'(1);
  localparam logic [16:0]         c_DEADBAND = 17'(DEADBAND);

  typedef enum logic [0:0] {
    S_CAL = 1'b0,
    S_RUN = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic signed [15:0]        w_raw  [3];
  logic signed [c_ACC_W-1:0] r_acc  [3];
  logic signed [c_ACC_W-1:0] w_sum  [3];
  logic signed [15:0]        w_avg  [3];
  logic signed [15:0]        w_corr [3];
  logic signed [15:0]        r_bias [3];
  logic signed [15:0]        r_out  [3];
  logic [CAL_LOG2-1:0]       r_cnt;
  logic                      r_valid;
  logic                      w_cal_last;
  logic                      w_cal_take;
  logic                      w_run_take;

  // 17-bit difference, clamp to 16 bits, then zero anything inside the deadband.
  function automatic logic signed [15:0] f_correct(
    input logic signed [15:0] raw,
    input logic signed [15:0] bias
  );
    logic signed [16:0] diff;
    logic signed [15:0] sat;
    logic signed [16:0] sat_ext;
    logic        [16:0] mag;
    diff = {raw[15], raw} - {bias[15], bias};
    if (diff > 17'sd32767) begin
      sat = 16'sh7FFF;
    end else if (diff < -17'sd32768) begin
      sat = 16'sh8000;
    end else begin
      sat = diff[15:0];
    end
    sat_ext = {sat[15], sat};
    mag     = sat_ext[16] ? -sat_ext : sat_ext;
    return (mag <= c_DEADBAND) ? 16'sd0 : sat;
  endfunction

  assign w_raw[0] = gx_in;
  assign w_raw[1] = gy_in;
  assign w_raw[2] = gz_in;

  generate
    for (genvar a = 0; a < 3; a++) begin : g_axis
      assign w_sum[a]  = r_acc[a] + {{CAL_LOG2{w_raw[a][15]}}, w_raw[a]};
      assign w_avg[a]  = 16'(w_sum[a] >>> CAL_LOG2);
      assign w_corr[a] = f_correct(w_raw[a], r_bias[a]);
    end
  endgenerate

  // A recal in the same cycle always suppresses the sample it arrives with.
  assign w_cal_take = (r_state == S_CAL) && valid_in && !recal_in;
  assign w_cal_last = w_cal_take && (r_cnt == c_LAST_CNT);
  assign w_run_take = (r_state == S_RUN) && valid_in && !recal_in;

  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      r_state <= S_CAL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CAL:   if (w_cal_last) w_next_state = S_RUN;
      S_RUN:   if (recal_in)   w_next_state = S_CAL;
      default: w_next_state = S_CAL;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        r_acc[a]  <= '0;
        r_bias[a] <= '0;
        r_out[a]  <= '0;
      end
    end else begin
      r_valid <= w_run_take;
      if (recal_in || w_cal_last) begin
        r_cnt <= '0;
        for (int a = 0; a < 3; a++) r_acc[a] <= '0;
      end else if (w_cal_take) begin
        r_cnt <= r_cnt + c_CNT_ONE;
        for (int a = 0; a < 3; a++) r_acc[a] <= w_sum[a];
      end
      if (w_cal_last) begin
        for (int a = 0; a < 3; a++) r_bias[a] <= w_avg[a];
      end
      if (w_run_take) begin
        for (int a = 0; a < 3; a++) r_out[a] <= w_corr[a];
      end
    end
  end

  assign gx_out       = r_out[0];
  assign gy_out       = r_out[1];
  assign gz_out       = r_out[2];
  assign valid_out    = r_valid;
  assign cal_done_out = (r_state == S_RUN);
  assign bias_x_out   = r_bias[0];
  assign bias_y_out   = r_bias[1];
  assign bias_z_out   = r_bias[2];

endmodule

`default_nettype wire
